// File: rtl/arbiter_out_fifo_pkg.sv
// Shared width helpers for the arbiter output FIFO.
package arbiter_out_fifo_pkg;

  // Pointer width that never collapses to zero bits for tiny depths.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arbiter_out_fifo_storage_ram.sv
// DEPTH x DWIDTH register array with one write port and an asynchronous read port.
module arbiter_out_fifo_storage_ram #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so no reset term keeps this LUTRAM-friendly.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/arbiter_out_fifo.sv
// Registered first-word-fall-through elastic buffer behind the fixed-priority arbiter.
module arbiter_out_fifo
  import arbiter_out_fifo_pkg::*;
#(
  parameter  int DWIDTH = 8,
  parameter  int DEPTH  = 4,
  localparam int CWIDTH = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [CWIDTH-1:0] count
);

  localparam int AW = ptr_width(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              push, pop;

  // Ready/valid come only from registered occupancy, cutting the out_ready -> in_ready path.
  assign in_ready  = (count_q != CWIDTH'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CWIDTH'(1);
      else if (pop && !push) count_d = count_q - CWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  arbiter_out_fifo_storage_ram #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH),
    .AWIDTH(AW)
  ) u_storage (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(in_data),
    .raddr(rd_ptr_q),
    .rdata(out_data)
  );

endmodule

// File: tb/tb_arbiter_out_fifo.sv
// Self-checking bench: queue model of the FIFO compared every cycle, plus literal anchors.
module tb_arbiter_out_fifo;

  localparam int DWIDTH = 8;
  localparam int DEPTH  = 4;
  localparam int CWIDTH = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic [CWIDTH-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [DWIDTH-1:0] model_q[$];
  logic [DWIDTH-1:0] got_q[$];
  logic [DWIDTH-1:0] all_got_q[$];
  bit                last_push;

  arbiter_out_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs against the queue model; out_data only matters while the model holds a word.
  task automatic compare_model();
    chk("count", int'(count), model_q.size());
    chk("in_ready", int'(in_ready), (model_q.size() < DEPTH) ? 1 : 0);
    chk("out_valid", int'(out_valid), (model_q.size() != 0) ? 1 : 0);
    if (model_q.size() != 0) chk("out_data", int'(out_data), int'(model_q[0]));
  endtask

  // One clock: predict transfers from the rules, clock, update model, then compare on negedge.
  task automatic step();
    bit m_push, m_pop;
    logic [DWIDTH-1:0] d;
    m_push = in_valid && (model_q.size() < DEPTH) && !flush;
    m_pop  = out_ready && (model_q.size() != 0) && !flush;
    d = in_data;
    if (out_valid && out_ready && !flush) begin
      got_q.push_back(out_data);
      all_got_q.push_back(out_data);
      $display("pop  data=0x%02h t=%0t", out_data, $time);
    end
    if (m_push) $display("push data=0x%02h t=%0t", d, $time);
    if (flush) $display("flush t=%0t", $time);
    @(posedge clk);
    if (m_pop) void'(model_q.pop_front());
    if (m_push) model_q.push_back(d);
    if (flush) model_q.delete();
    last_push = m_push;
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  initial begin
    logic [DWIDTH-1:0] exp_fill [5];
    int n;
    bit seen_7e;
    exp_fill = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    // Power-on reset
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst_n = 1;
    step();

    // Single word with 1-cycle latency
    in_valid = 1; in_data = 8'hA5; out_ready = 1;
    step();
    in_valid = 0;
    chk("single_valid", int'(out_valid), 1);
    chk("single_data", int'(out_data), 8'hA5);
    step();
    chk("single_drain_count", int'(count), 0);

    // Fill to full, held 5th word, then drain in order
    got_q.delete();
    out_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = DWIDTH'(i);
      step();
    end
    in_data = 8'h05;
    step(); step();
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    out_ready = 1;
    n = 0;
    while (in_valid && n < 10) begin
      step();
      if (last_push) in_valid = 0;
      n++;
    end
    n = 0;
    while (model_q.size() != 0 && n < 10) begin step(); n++; end
    chk("fill_pop_count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("fill_order", int'(got_q[i]), int'(exp_fill[i]));

    // Full with simultaneous pop, then push&pop at count 3
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 8'h40 + DWIDTH'(i);
      step();
    end
    chk("full2_count", int'(count), 4);
    out_ready = 1; in_data = 8'h50;
    step();
    chk("full_pop_count", int'(count), 3);
    chk("full_pop_in_ready", int'(in_ready), 1);
    step();
    chk("push_pop_count", int'(count), 3);
    in_valid = 0;
    n = 0;
    while (model_q.size() != 0 && n < 10) begin step(); n++; end

    // Streaming 20 words with wrap
    got_q.delete();
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1; in_data = 8'h10 + DWIDTH'(i);
      step();
      chk("stream_count", int'(count), 1);
    end
    in_valid = 0;
    step();
    chk("stream_len", got_q.size(), 20);
    for (int i = 0; i < 20 && i < got_q.size(); i++) chk("stream_order", int'(got_q[i]), 8'h10 + i);

    // Flush with concurrent push
    out_ready = 0;
    in_valid = 1; in_data = 8'h61; step();
    in_data = 8'h62; step();
    chk("preflush_count", int'(count), 2);
    flush = 1; in_data = 8'h7E;
    step();
    flush = 0; in_valid = 0;
    chk("flush_count", int'(count), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    out_ready = 1;
    repeat (3) step();

    // Asynchronous reset mid-stream at count=3
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 8'h90 + DWIDTH'(i);
      step();
    end
    in_valid = 0;
    chk("prereset_count", int'(count), 3);
    #2 rst_n = 0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_in_ready", int'(in_ready), 1);
    model_q.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    repeat (3) step();

    seen_7e = 0;
    foreach (all_got_q[i]) if (all_got_q[i] == 8'h7E) seen_7e = 1;
    chk("flushed_word_absent", int'(seen_7e), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
